// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART TX arbiter.
//   arb_state_e : arbiter FSM state encoding
//   BYTE_W      : width of one requester byte
//   TIMEOUT_CYC_DEF : default tx_start-to-done budget for the optional timeout
//   UART_DVSR, OVERSAMPLE : UART TX timing constants, used by benches
package uart_arb_pkg;

  localparam int BYTE_W          = 8;
  localparam int TIMEOUT_CYC_DEF = 8192;
  localparam int UART_DVSR       = 26;
  localparam int OVERSAMPLE      = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GRANT     = 2'd1,
    START     = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin picker (module rr_arbiter).
// Searches req_i starting at index ptr_i and wrapping mod N; returns the
// first set index. Also used by the RX demux.
//   req_i  : request vector
//   ptr_i  : index with highest priority this cycle
//   gnt_o  : granted index (0 when no request)
//   any_o  : at least one request bit set
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] gnt_o,
  output logic          any_o
);

  logic found;
  int   idx;

  always_comb begin
    gnt_o = '0;
    any_o = |req_i;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_i) + k) % N;
      if (!found && req_i[idx]) begin
        gnt_o = IW'(idx);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte producers.
// One byte per grant; sequences the transmitter start/done handshake.
// Optional feature: define TX_TIMEOUT_EN to add a tx_done_tick watchdog and
// the sticky timeout_err_o output.
//
// Ports:
//   clk_i, rst_ni    : clock (rising edge), async active-low reset
//   req_valid_i      : per-requester byte pending
//   req_data_i       : flattened bytes, requester i at [8i+7:8i]
//   req_ready_o      : one-hot accept strobe (GRANT state)
//   tx_start_o       : one-cycle start pulse to the UART TX unit
//   tx_data_o        : byte being transmitted, held until the next capture
//   tx_done_tick_i   : end-of-stop-bit pulse from the UART TX unit
//   busy_o           : FSM not in IDLE
//   grant_id_o       : current or last granted requester
//   timeout_err_o    : sticky watchdog flag (TX_TIMEOUT_EN only)
//
// state     | meaning
// IDLE      | waiting for any req_valid; arbitration decision registered
// GRANT     | req_ready to the winner; capture byte or abandon if dropped
// START     | tx_start pulse
// WAIT_DONE | waiting for tx_done_tick (or watchdog expiry)
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int IW          = $clog2(NREQ)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NREQ-1:0]        req_valid_i,
  input  logic [NREQ*BYTE_W-1:0] req_data_i,
  output logic [NREQ-1:0]        req_ready_o,
  output logic                   tx_start_o,
  output logic [BYTE_W-1:0]      tx_data_o,
  input  logic                   tx_done_tick_i,
`ifdef TX_TIMEOUT_EN
  output logic                   timeout_err_o,
`endif
  output logic                   busy_o,
  output logic [IW-1:0]          grant_id_o
);

  arb_state_e        state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     gid_q, gid_d;
  logic [BYTE_W-1:0] data_q, data_d;
  logic [IW-1:0]     arb_gnt;
  logic              arb_any;
  logic [IW-1:0]     gid_next;

`ifdef TX_TIMEOUT_EN
  // cnt_q holds the number of cycles elapsed since the tx_start cycle.
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
`endif

  rr_arbiter #(.N(NREQ), .IW(IW)) u_rr (
    .req_i (req_valid_i),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .any_o (arb_any)
  );

  assign gid_next = (gid_q == IW'(NREQ - 1)) ? '0 : gid_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gid_d       = gid_q;
    data_d      = data_q;
    req_ready_o = '0;
    tx_start_o  = 1'b0;
`ifdef TX_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          gid_d   = arb_gnt;
          state_d = GRANT;
        end
      end
      GRANT: begin
        req_ready_o[gid_q] = 1'b1;
        if (req_valid_i[gid_q]) begin
          data_d  = req_data_i[int'(gid_q)*BYTE_W +: BYTE_W];
          state_d = START;
        end else begin
          // requester withdrew: nothing transferred, pointer untouched
          state_d = IDLE;
        end
      end
      START: begin
        tx_start_o = 1'b1;
        state_d    = WAIT_DONE;
`ifdef TX_TIMEOUT_EN
        cnt_d      = 16'd1;
`endif
      end
      WAIT_DONE: begin
        if (tx_done_tick_i) begin
          ptr_d   = gid_next;
          state_d = IDLE;
`ifdef TX_TIMEOUT_EN
        end else if (cnt_q == 16'(TIMEOUT_CYC - 1)) begin
          // counter would reach TIMEOUT_CYC this edge; done has priority above
          err_d   = 1'b1;
          ptr_d   = gid_next;
          state_d = IDLE;
        end else begin
          cnt_d   = cnt_q + 16'd1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gid_q   <= '0;
      data_q  <= '0;
`ifdef TX_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      data_q  <= data_d;
`ifdef TX_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign tx_data_o  = data_q;
  assign busy_o     = (state_q != IDLE);
  assign grant_id_o = gid_q;
`ifdef TX_TIMEOUT_EN
  assign timeout_err_o = err_q;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (NREQ=4). Expected (requester, byte)
// pairs are queued by the stimulus; a monitor pops and compares on tx_start and
// acts as the UART TX unit, returning tx_done_tick after a short delay.
// Define TX_TIMEOUT_EN to also exercise the watchdog.
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int TCYC = 8192;
  localparam int DLY  = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_done_tick;
  logic        busy;
  logic [1:0]  grant_id;
`ifdef TX_TIMEOUT_EN
  logic        timeout_err;
`endif

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(TCYC)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .req_valid_i    (req_valid),
    .req_data_i     (req_data),
    .req_ready_o    (req_ready),
    .tx_start_o     (tx_start),
    .tx_data_o      (tx_data),
    .tx_done_tick_i (tx_done_tick),
`ifdef TX_TIMEOUT_EN
    .timeout_err_o  (timeout_err),
`endif
    .busy_o         (busy),
    .grant_id_o     (grant_id)
  );

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] d;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   n_start = 0;
  int   start_cyc = 0;
  int   done_cyc = -100;
  int   done_cnt = -1;
  bit   withhold = 1'b0;
  bit   gap_chk = 1'b0;
  int   pend[4];
  logic [3:0] acc;
  logic [3:0] drop_mode;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int id, input logic [7:0] d);
    exp_t e;
    e.id = id[1:0];
    e.d  = d;
    sbq.push_back(e);
  endtask

  // Monitor / scoreboard and UART TX unit model.
  initial begin
    exp_t e;
    tx_done_tick = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_done_tick) tx_done_tick = 1'b0;
      if (done_cnt > 0) done_cnt--;
      if (done_cnt == 0) begin
        tx_done_tick = 1'b1;
        done_cyc     = cyc;
        done_cnt     = -1;
      end
      if (tx_start) begin
        n_start++;
        start_cyc = cyc;
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_start: got tx_start with data %0h, expected none", tx_data);
        end else begin
          e = sbq.pop_front();
          chk("sb_tx_data", {24'd0, tx_data}, {24'd0, e.d});
          chk("sb_grant_id", {30'd0, grant_id}, {30'd0, e.id});
        end
        if (gap_chk && done_cyc >= 0) chk("done_to_start_gap", cyc - done_cyc, 3);
        if (!withhold) done_cnt = DLY;
      end
    end
  end

  // One cycle of requester behaviour: drop valid after an accepted transfer,
  // or withdraw during GRANT when drop_mode is armed.
  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < 4; i++) if (acc[i]) pend[i]--;
    acc = '0;
    for (int i = 0; i < 4; i++) begin
      if (rst_n && req_ready[i]) begin
        if (drop_mode[i]) begin
          pend[i]      = 0;
          drop_mode[i] = 1'b0;
        end else begin
          acc[i] = 1'b1;
        end
      end
    end
    for (int i = 0; i < 4; i++) req_valid[i] = (pend[i] > 0);
  endtask

  task automatic post(input int i, input int n);
    pend[i]      = pend[i] + n;
    req_valid[i] = 1'b1;
  endtask

  task automatic wait_quiet(input string nm, input int bound);
    int n = 0;
    while ((busy || sbq.size() != 0 || done_cnt >= 0 || tx_done_tick ||
            pend[0] != 0 || pend[1] != 0 || pend[2] != 0 || pend[3] != 0) && n < bound) begin
      tick();
      n++;
    end
    checks++;
    if (n >= bound) begin
      failures++;
      $display("FAIL %s: still busy after %0d cycles, queued=%0d expected idle", nm, n, sbq.size());
    end
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_req_ready"}, {28'd0, req_ready}, 32'd0);
    chk({nm, "_tx_start"},  {31'd0, tx_start},  32'd0);
    chk({nm, "_tx_data"},   {24'd0, tx_data},   32'd0);
    chk({nm, "_busy"},      {31'd0, busy},      32'd0);
    chk({nm, "_grant_id"},  {30'd0, grant_id},  32'd0);
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) pend[i] = 0;
    acc = '0;
    req_valid = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int ns;
    int n;
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = {8'h3f, 8'h0c, 8'h0a, 8'h05};
    acc       = '0;
    drop_mode = '0;
    for (int i = 0; i < 4; i++) pend[i] = 0;
    #12;
    chk_reset_outs("reset");
`ifdef TX_TIMEOUT_EN
    chk("reset_timeout_err", {31'd0, timeout_err}, 32'd0);
`endif
    tick();
    rst_n = 1'b1;
    tick();

    // Single request from requester 1: ready at +1, start at +2.
    push_exp(1, 8'h0a);
    post(1, 1);
    tick();
    chk("single_req_ready", {28'd0, req_ready}, 32'h2);
    chk("single_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("single_tx_start", {31'd0, tx_start}, 32'd1);
    wait_quiet("single_wait", 200);
    chk("single_busy_after", {31'd0, busy}, 32'd0);
    chk("single_grant_id", {30'd0, grant_id}, 32'd1);

    // All four requesters; requester 0 has two bytes so the pointer wraps.
    do_reset();
    gap_chk  = 1'b1;
    done_cyc = -100;
    push_exp(0, 8'h05);
    push_exp(1, 8'h0a);
    push_exp(2, 8'h0c);
    push_exp(3, 8'h3f);
    push_exp(0, 8'h05);
    post(0, 2);
    post(1, 1);
    post(2, 1);
    post(3, 1);
    wait_quiet("all_wait", 500);
    gap_chk = 1'b0;
    chk("all_last_grant", {30'd0, grant_id}, 32'd0);

    // Requester 2 withdraws during GRANT (pointer is 1 here).
    ns = n_start;
    drop_mode[2] = 1'b1;
    post(2, 1);
    n = 0;
    while (drop_mode[2] && n < 20) begin
      tick();
      n++;
    end
    chk("drop_saw_grant", {31'd0, drop_mode[2]}, 32'd0);
    for (int i = 0; i < 5; i++) tick();
    chk("drop_no_start", n_start, ns);
    chk("drop_busy", {31'd0, busy}, 32'd0);
    // Pointer still 1: requester 1 wins over 3.
    push_exp(1, 8'h0a);
    push_exp(3, 8'h3f);
    post(1, 1);
    post(3, 1);
    wait_quiet("drop_follow_wait", 300);

    // Reset during WAIT_DONE (pointer 0, grant 1 in flight).
    push_exp(1, 8'h0a);
    post(1, 1);
    ns = n_start;
    n  = 0;
    while (n_start == ns && n < 20) begin
      tick();
      n++;
    end
    chk("rst_start_seen", n_start, ns + 1);
    for (int i = 0; i < 5; i++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outs("async_rst");
    tick();
    tick();
    rst_n = 1'b1;
    ns = n_start;
    // Model still returns the stale done tick; it must be ignored.
    for (int i = 0; i < 30; i++) tick();
    chk("stale_done_fired", {31'd0, (done_cyc > 0 && done_cnt < 0)}, 32'd1);
    chk("stale_no_start", n_start, ns);
    chk("stale_busy", {31'd0, busy}, 32'd0);
    // Pointer back at 0: requester 0 before 3.
    push_exp(0, 8'h05);
    push_exp(3, 8'h3f);
    post(3, 1);
    post(0, 1);
    wait_quiet("post_rst_wait", 300);
    chk("post_rst_grant_id", {30'd0, grant_id}, 32'd3);

`ifdef TX_TIMEOUT_EN
    // Withhold done: error exactly TCYC cycles after tx_start.
    withhold = 1'b1;
    push_exp(2, 8'h0c);
    post(2, 1);
    ns = n_start;
    n  = 0;
    while (n_start == ns && n < 20) begin
      tick();
      n++;
    end
    chk("to_start_seen", n_start, ns + 1);
    n = 0;
    while (!timeout_err && n < TCYC + 50) begin
      tick();
      n++;
    end
    chk("to_latency", cyc - start_cyc, TCYC);
    chk("to_busy", {31'd0, busy}, 32'd0);
    withhold = 1'b0;
    // Pointer now 3: requester 3 served before 0.
    push_exp(3, 8'h3f);
    push_exp(0, 8'h05);
    post(0, 1);
    post(3, 1);
    wait_quiet("to_follow_wait", 300);
    chk("to_sticky", {31'd0, timeout_err}, 32'd1);
    do_reset();
    chk("to_cleared", {31'd0, timeout_err}, 32'd0);
`endif

    chk("sb_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule
